// File: rtl/lcd_nibble_ctrl_pkg.sv
// Shared types and constants for the 4-bit HD44780 LCD controller.
// Holds the FSM state enum, the init nibble sequence and the long-command test.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE
  } state_t;

  // Init nibble i sits at bits [4i+3:4i]: 3,3,3,2
  localparam logic [15:0] INIT_SEQ = 16'h2333;
  localparam int          INIT_LEN = 4;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_HOME2 = 8'h03;

  function automatic logic [3:0] init_nibble(
    input logic [1:0] i
  );
    return INIT_SEQ[{i, 2'b00} +: 4];
  endfunction

  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] d
  );
    return !rs && (d == CMD_CLEAR ||
                   d == CMD_HOME  ||
                   d == CMD_HOME2);
  endfunction

endpackage

// File: rtl/lcd_nibble_ctrl_if.sv
// Valid/ready byte channel into the LCD controller.
// Ports: in_valid, in_data, in_rs (to slave), in_ready (from slave).
interface lcd_nibble_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_rs;

  modport master (
    output in_valid, in_data, in_rs,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_rs,
    output in_ready
  );
endinterface

// File: rtl/lcd_nibble_ctrl_dly.sv
// Loadable down-counter shared by all timed states of the LCD controller.
// Ports: CLK, RST, load, load_val -> zero (count is 0).
module lcd_dly_cnt #(
  parameter int unsigned      CNT_W   = 24,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  assign zero = (cnt == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= RST_VAL;
    else if (load)
      cnt <= load_val;
    else if (!zero)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/lcd_nibble_ctrl.sv
// Write-only 4-bit HD44780 controller: power-up init, then bytes as two nibbles.
// Ports: CLK, RST, bus (slave byte channel), init_done, lcd_db/lcd_e/lcd_rs/lcd_rw.
module lcd_nibble_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned T_PWRUP = 1875000,
  parameter int unsigned T_AS    = 8,
  parameter int unsigned T_PW    = 60,
  parameter int unsigned T_H     = 8,
  parameter int unsigned T_CMD   = 6250,
  parameter int unsigned T_LONG  = 205000
) (
  input  logic               CLK,
  input  logic               RST,
  lcd_nibble_ctrl_if.slave   bus,
  output logic               init_done,
  output logic [3:0]         lcd_db,
  output logic               lcd_e,
  output logic               lcd_rs,
  output logic               lcd_rw
);

  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] LD_AS    = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_H     = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);
  localparam logic [1:0]       IDX_LAST = 2'(INIT_LEN - 1);

  state_t           state, state_n;
  logic [3:0]       db_q, db_n;
  logic             rs_q, rs_n;
  logic             e_q, e_n;
  logic             ready_q, ready_n;
  logic             done_q, done_n;
  logic             hi_q, hi_n;
  logic             init_q, init_n;
  logic [1:0]       idx_q, idx_n;
  logic [3:0]       lo_q, lo_n;
  logic             long_q, long_n;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  lcd_dly_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_PWRUP)
  ) u_dly (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  assign lcd_db       = db_q;
  assign lcd_rs       = rs_q;
  assign lcd_e        = e_q;
  assign lcd_rw       = 1'b0;
  assign init_done    = done_q;
  assign bus.in_ready = ready_q;

  always_comb begin
    state_n  = state;
    db_n     = db_q;
    rs_n     = rs_q;
    e_n      = 1'b0;
    ready_n  = 1'b0;
    done_n   = done_q;
    hi_n     = hi_q;
    init_n   = init_q;
    idx_n    = idx_q;
    lo_n     = lo_q;
    long_n   = long_q;
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      PWRUP: begin
        if (zero) begin
          state_n  = SETUP;
          db_n     = init_nibble(2'd0);
          rs_n     = 1'b0;
          init_n   = 1'b1;
          idx_n    = 2'd0;
          hi_n     = 1'b1;
          load     = 1'b1;
          load_val = LD_AS;
        end
      end
      SETUP: begin
        if (zero) begin
          state_n  = PULSE;
          e_n      = 1'b1;
          load     = 1'b1;
          load_val = LD_PW;
        end
      end
      PULSE: begin
        e_n = 1'b1;
        if (zero) begin
          state_n  = HOLD;
          e_n      = 1'b0;
          load     = 1'b1;
          load_val = LD_H;
        end
      end
      HOLD: begin
        if (zero) begin
          load = 1'b1;
          if (!init_q && hi_q) begin
            state_n  = SETUP;
            db_n     = lo_q;
            hi_n     = 1'b0;
            load_val = LD_AS;
          end else begin
            state_n  = WAIT;
            load_val = (init_q || long_q) ? LD_LONG : LD_CMD;
          end
        end
      end
      WAIT: begin
        if (zero) begin
          if (init_q && idx_q != IDX_LAST) begin
            state_n  = SETUP;
            idx_n    = idx_q + 2'd1;
            db_n     = init_nibble(idx_q + 2'd1);
            load     = 1'b1;
            load_val = LD_AS;
          end else begin
            // init_done and in_ready rise together at end of init
            state_n = IDLE;
            init_n  = 1'b0;
            done_n  = 1'b1;
            ready_n = 1'b1;
          end
        end
      end
      IDLE: begin
        ready_n = 1'b1;
        if (bus.in_valid && ready_q) begin
          state_n  = SETUP;
          ready_n  = 1'b0;
          db_n     = bus.in_data[7:4];
          rs_n     = bus.in_rs;
          lo_n     = bus.in_data[3:0];
          long_n   = is_long_cmd(bus.in_rs, bus.in_data);
          hi_n     = 1'b1;
          load     = 1'b1;
          load_val = LD_AS;
        end
      end
      default: state_n = PWRUP;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= PWRUP;
      db_q    <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 1'b0;
      init_q  <= 1'b0;
      idx_q   <= '0;
      lo_q    <= '0;
      long_q  <= 1'b0;
    end else begin
      state   <= state_n;
      db_q    <= db_n;
      rs_q    <= rs_n;
      e_q     <= e_n;
      ready_q <= ready_n;
      done_q  <= done_n;
      hi_q    <= hi_n;
      init_q  <= init_n;
      idx_q   <= idx_n;
      lo_q    <= lo_n;
      long_q  <= long_n;
    end
  end

endmodule

// File: tb/tb_lcd_nibble_ctrl.sv
// Directed bench for lcd_nibble_ctrl with short timing parameters.
// A negedge monitor logs every lcd_e pulse (nibble, rs, rise cycle, width).
module tb_lcd_nibble_ctrl;

  localparam int CNT_W   = 24;
  localparam int T_PWRUP = 20;
  localparam int T_AS    = 2;
  localparam int T_PW    = 4;
  localparam int T_H     = 2;
  localparam int T_CMD   = 10;
  localparam int T_LONG  = 30;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       init_done;
  logic [3:0] lcd_db;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  lcd_nibble_ctrl_if bus();

  lcd_nibble_ctrl #(
    .CNT_W   (CNT_W),
    .T_PWRUP (T_PWRUP),
    .T_AS    (T_AS),
    .T_PW    (T_PW),
    .T_H     (T_H),
    .T_CMD   (T_CMD),
    .T_LONG  (T_LONG)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus.slave),
    .init_done (init_done),
    .lcd_db    (lcd_db),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [3:0] nib_q[$];
  logic       rsq_q[$];
  int         rise_q[$];
  int         wid_q[$];
  int         wcnt     = 0;
  logic       e_prev   = 1'b0;
  logic [3:0] db_prev  = '0;
  logic       rs_prev  = 1'b0;
  int         stab_err = 0;
  int         rw_err   = 0;

  always @(negedge CLK) begin
    if (lcd_e === 1'b1 && e_prev === 1'b0) begin
      nib_q.push_back(lcd_db);
      rsq_q.push_back(lcd_rs);
      rise_q.push_back(cyc);
    end
    if (lcd_e === 1'b1 && e_prev === 1'b1 &&
        (lcd_db !== db_prev || lcd_rs !== rs_prev))
      stab_err++;
    if (lcd_e === 1'b0 && e_prev === 1'b1)
      wid_q.push_back(wcnt);
    if (lcd_e === 1'b1)
      wcnt = (e_prev === 1'b1) ? wcnt + 1 : 1;
    else
      wcnt = 0;
    if (lcd_rw !== 1'b0)
      rw_err++;
    e_prev  = lcd_e;
    db_prev = lcd_db;
    rs_prev = lcd_rs;
  end

  task automatic clear_mon();
    nib_q.delete();
    rsq_q.delete();
    rise_q.delete();
    wid_q.delete();
  endtask

  task automatic run_init(input bit poke, input string tag);
    int  base;
    int  lat;
    bit  seen;
    logic [3:0] exp_nib[4];
    exp_nib = '{4'h3, 4'h3, 4'h3, 4'h2};
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    clear_mon();
    RST  = 1'b0;
    base = cyc;
    seen = 1'b0;
    lat  = -1;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (poke) begin
        bus.in_valid = (k % 3 == 0);
        bus.in_data  = 8'hAA;
        bus.in_rs    = 1'b1;
      end
      @(negedge CLK);
      if (init_done === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - base;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!seen || lat != 172) begin
      errors++;
      $display("FAIL %s init_lat: got %0d want 172", tag, lat);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_at_done: got %b want 1", tag, bus.in_ready);
    end
    checks++;
    if (nib_q.size() != 4) begin
      errors++;
      $display("FAIL %s init_pulses: got %0d want 4", tag, nib_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (nib_q[i] !== exp_nib[i] || rsq_q[i] !== 1'b0 || wid_q[i] != 4) begin
          errors++;
          $display("FAIL %s init_nib%0d: got db=%h rs=%b w=%0d want db=%h rs=0 w=4",
                   tag, i, nib_q[i], rsq_q[i], wid_q[i], exp_nib[i]);
        end
      end
    end
    checks++;
    if (rw_err != 0 || stab_err != 0) begin
      errors++;
      $display("FAIL %s rw_stab: got rw_err=%0d stab_err=%0d want 0 0",
               tag, rw_err, stab_err);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic rs,
                           output int lat, output int acc);
    for (int k = 0; k < 300 && bus.in_ready !== 1'b1; k++)
      @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_rs    = rs;
    @(negedge CLK);
    acc          = cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_rs    = 1'b0;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (bus.in_ready === 1'b1) begin
        lat = cyc - acc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_rs    = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({lcd_db, lcd_e, lcd_rs, lcd_rw, bus.in_ready, init_done} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outs: got db=%h e=%b rs=%b rw=%b rdy=%b done=%b want all 0",
               lcd_db, lcd_e, lcd_rs, lcd_rw, bus.in_ready, init_done);
    end
  endtask

  task automatic test_char();
    int lat, acc;
    clear_mon();
    send_byte(8'h48, 1'b1, lat, acc);
    @(negedge CLK);
    checks++;
    if (lat != 26) begin
      errors++;
      $display("FAIL char_lat: got %0d want 26", lat);
    end
    checks++;
    if (nib_q.size() != 2) begin
      errors++;
      $display("FAIL char_pulses: got %0d want 2", nib_q.size());
    end else begin
      checks++;
      if (nib_q[0] !== 4'h4 || nib_q[1] !== 4'h8 ||
          rsq_q[0] !== 1'b1 || rsq_q[1] !== 1'b1) begin
        errors++;
        $display("FAIL char_nibs: got %h%h rs=%b%b want 48 rs=11",
                 nib_q[0], nib_q[1], rsq_q[0], rsq_q[1]);
      end
      checks++;
      if (rise_q[0] - acc != 2 || rise_q[1] - acc != 10 ||
          wid_q[0] != 4 || wid_q[1] != 4) begin
        errors++;
        $display("FAIL char_timing: got rise %0d,%0d w %0d,%0d want 2,10 w 4,4",
                 rise_q[0] - acc, rise_q[1] - acc, wid_q[0], wid_q[1]);
      end
    end
    checks++;
    if (lcd_db !== 4'h8 || lcd_rs !== 1'b1 || lcd_e !== 1'b0) begin
      errors++;
      $display("FAIL char_idle_hold: got db=%h rs=%b e=%b want 8 1 0",
               lcd_db, lcd_rs, lcd_e);
    end
  endtask

  task automatic test_long_cmd();
    int lat, acc;
    logic [7:0] dv[4];
    logic       rv[4];
    int         ev[4];
    dv = '{8'h01, 8'h01, 8'h03, 8'h04};
    rv = '{1'b0, 1'b1, 1'b0, 1'b0};
    ev = '{46, 26, 46, 26};
    for (int i = 0; i < 4; i++) begin
      clear_mon();
      send_byte(dv[i], rv[i], lat, acc);
      @(negedge CLK);
      checks++;
      if (lat != ev[i]) begin
        errors++;
        $display("FAIL long_lat%0d: data=%h rs=%b got %0d want %0d",
                 i, dv[i], rv[i], lat, ev[i]);
      end
      if (i == 0) begin
        checks++;
        if (nib_q.size() != 2 || nib_q[0] !== 4'h0 || nib_q[1] !== 4'h1 ||
            rsq_q[0] !== 1'b0) begin
          errors++;
          $display("FAIL long_nibs: got n=%0d want 0,1 rs=0", nib_q.size());
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2;
    bit got;
    clear_mon();
    for (int k = 0; k < 300 && bus.in_ready !== 1'b1; k++)
      @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    bus.in_rs    = 1'b1;
    @(negedge CLK);
    a1 = cyc;
    bus.in_data = 8'h42;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_drop: got %b want 0", bus.in_ready);
    end
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge CLK);
      if (bus.in_ready === 1'b1) got = 1'b1;
    end
    @(negedge CLK);
    a2 = cyc;
    bus.in_valid = 1'b0;
    checks++;
    if (!got || a2 - a1 != 27 || bus.in_ready !== 1'b0 || lcd_db !== 4'h4) begin
      errors++;
      $display("FAIL b2b_second_accept: got gap=%0d rdy=%b db=%h want 27 0 4",
               a2 - a1, bus.in_ready, lcd_db);
    end
    for (int k = 0; k < 300 && bus.in_ready !== 1'b1; k++)
      @(negedge CLK);
    repeat (3) @(negedge CLK);
    checks++;
    if (nib_q.size() != 4 || nib_q[0] !== 4'h4 || nib_q[1] !== 4'h1 ||
        nib_q[2] !== 4'h4 || nib_q[3] !== 4'h2) begin
      errors++;
      $display("FAIL b2b_nibs: got n=%0d want 4,1,4,2", nib_q.size());
    end
  endtask

  task automatic test_wait_ignore();
    int acc, lat;
    clear_mon();
    for (int k = 0; k < 300 && bus.in_ready !== 1'b1; k++)
      @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h48;
    bus.in_rs    = 1'b1;
    @(negedge CLK);
    acc = cyc;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 100 && cyc < acc + 18; k++)
      @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_rs    = 1'b0;
    repeat (4) @(negedge CLK);
    bus.in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      if (bus.in_ready === 1'b1) begin
        lat = cyc - acc;
        break;
      end
      @(negedge CLK);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (lat != 26 || nib_q.size() != 2 || lcd_rs !== 1'b1 || lcd_db !== 4'h8) begin
      errors++;
      $display("FAIL wait_ignore: got lat=%0d pulses=%0d rs=%b db=%h want 26 2 1 8",
               lat, nib_q.size(), lcd_rs, lcd_db);
    end
  endtask

  task automatic test_reset_mid();
    int lat, acc;
    clear_mon();
    for (int k = 0; k < 300 && bus.in_ready !== 1'b1; k++)
      @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h48;
    bus.in_rs    = 1'b1;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 100 && rise_q.size() < 2; k++)
      @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (lcd_e !== 1'b1 || lcd_db !== 4'h8) begin
      errors++;
      $display("FAIL mid_in_pulse: got e=%b db=%h want 1 8", lcd_e, lcd_db);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (lcd_e !== 1'b0 || bus.in_ready !== 1'b0 || init_done !== 1'b0 ||
        lcd_db !== 4'h0 || lcd_rs !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: got e=%b rdy=%b done=%b db=%h rs=%b want 0",
               lcd_e, bus.in_ready, init_done, lcd_db, lcd_rs);
    end
    run_init(1'b0, "reinit");
    send_byte(8'h41, 1'b1, lat, acc);
    checks++;
    if (lat != 26) begin
      errors++;
      $display("FAIL reinit_byte_lat: got %0d want 26", lat);
    end
  endtask

  initial begin
    test_reset();
    run_init(1'b0, "init");
    test_char();
    test_long_cmd();
    test_back_to_back();
    test_wait_ignore();
    test_reset_mid();
    run_init(1'b1, "init_poke");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_ctrl.md
Name: lcd_nibble_ctrl

Overview:
Write-only controller for the ml605 character LCD in 4-bit HD44780 mode. It drives lcd_db/lcd_e/lcd_rs/lcd_rw, the LCD pins exported by the FPGA top level.
- At reset it runs the power-up nibble sequence itself.
- It then accepts command or data bytes from the control plane over a valid/ready handshake.
- Each byte goes out as two nibbles, high nibble first, with programmable setup, pulse, hold and post-command timing.

Parameters:
CNT_W, 24, width of the shared delay counter; every T_* value must be < 2**CNT_W
T_PWRUP, 1875000, cycles held idle after reset before the first nibble (15 ms at 125 MHz)
T_AS, 8, cycles lcd_db/lcd_rs are stable before lcd_e rises; minimum 1
T_PW, 60, cycles lcd_e is high; minimum 1
T_H, 8, cycles lcd_e is low after each pulse before lcd_db changes; minimum 1
T_CMD, 6250, post-byte wait for normal commands and data (50 us)
T_LONG, 205000, post-byte wait for clear/home and after each init nibble (1.64 ms)

Ports:
CLK  in  1  single clock; every register is on its rising edge
RST  in  1  asynchronous, active-high reset
in_valid  in  1  a byte is offered
in_ready  out  1  controller can accept a byte
in_data  in  8  byte to write
in_rs  in  1  0 = command register, 1 = data register
init_done  out  1  power-up sequence complete; sticky until RST
lcd_db  out  4  LCD data nibble
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; tied 0, write-only

Behaviour:
- Reset: while RST is high, force all outputs to 0 (lcd_db, lcd_e, lcd_rs, lcd_rw, in_ready, init_done) and the FSM to PWRUP. The effect is asynchronous.
- Reset mid-byte or mid-init: the strobe is abandoned immediately. After RST deasserts, the full power-up sequence restarts.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: PWRUP, SETUP, PULSE, HOLD, WAIT, IDLE.
  - SETUP, PULSE and HOLD carry a nibble-select bit (hi/lo) and an init flag.
- PWRUP: count T_PWRUP cycles, then load init nibble 0 and enter SETUP.
- Init sequence: nibbles 0x3, 0x3, 0x3, 0x2, all with lcd_rs=0.
  - Each nibble runs SETUP -> PULSE -> HOLD, then WAIT for T_LONG.
  - After the fourth WAIT: set init_done=1 and in_ready=1 together, enter IDLE.
  - Total from RST release to init_done: T_PWRUP + 4*(T_AS+T_PW+T_H+T_LONG) cycles.
- Nibble timing:
  - SETUP: lcd_db/lcd_rs valid, lcd_e=0, for T_AS cycles.
  - PULSE: lcd_e=1 for T_PW cycles.
  - HOLD: lcd_e=0 for T_H cycles.
  - lcd_db and lcd_rs must not change during PULSE or HOLD.
- Handshake:
  - A byte is accepted on a cycle where in_valid && in_ready.
  - in_ready is 1 only in IDLE and drops on the cycle after acceptance.
  - in_valid while not ready is ignored; nothing is queued. in_data/in_rs are don't-care when not accepted.
- Byte transfer:
  - On the acceptance edge, register the byte: lcd_db = in_data[7:4], lcd_rs = in_rs, enter SETUP(hi).
  - After HOLD(hi): lcd_db = in_data[3:0], enter SETUP(lo).
  - After HOLD(lo): enter WAIT.
- Post-byte wait: T_LONG if in_rs==0 and in_data is 0x01, 0x02 or 0x03; T_CMD otherwise.
- Return to IDLE: in_ready reasserts exactly 2*(T_AS+T_PW+T_H) + wait cycles after the acceptance edge.
- IDLE: lcd_e=0; lcd_db and lcd_rs keep their last values.
- Counter: one down-counter of width CNT_W, loaded with (T_x - 1) on state entry; the state exits when the count reaches 0. No wrap is possible because all loads are below 2**CNT_W.

Decomposition:
- Package lcd_pkg:
  - state enum;
  - init nibble constants (INIT_SEQ = 3,3,3,2; INIT_LEN = 4);
  - long-command codes 0x01/0x02/0x03;
  - is_long_cmd() function.
- Sub-module lcd_dly_cnt: loadable CNT_W down-counter with load, load value and a zero flag.
- The FSM and output registers live in lcd_nibble_ctrl.

Test Plan:
All scenarios use T_PWRUP=20, T_AS=2, T_PW=4, T_H=2, T_CMD=10, T_LONG=30.
1. Release RST -> lcd_e pulses 4 times with lcd_db 3,3,3,2 and lcd_rs=0, each pulse 4 cycles wide; init_done and in_ready rise 172 cycles after release; lcd_rw stays 0 throughout.
2. After init, send in_data=0x48, in_rs=1 -> lcd_db=0x4, then 0x8, with lcd_rs=1; lcd_e rises 2 cycles after each nibble is set up; in_ready returns 26 cycles after the acceptance edge.
3. Send in_data=0x01, in_rs=0 -> two nibbles 0x0 then 0x1; in_ready returns after 46 cycles. Then send 0x01 with in_rs=1 -> in_ready returns after 26 cycles.
4. Hold in_valid=1 continuously with bytes 0x41, 0x42 -> exactly two transfers; the second is accepted on the cycle in_ready is seen high; no byte is dropped or duplicated.
5. Assert RST during PULSE of the low nibble -> lcd_e, in_ready and init_done go to 0 asynchronously; after release, the full 172-cycle init sequence repeats.
6. Pulse in_valid during the init sequence and during WAIT -> no acceptance and no extra lcd_e pulses.
